// File: rtl/instruction_fetch_pkg.sv
// Shared widths and fetch state encoding for the instruction fetch stage.
package instruction_fetch_pkg;

    localparam int INSTR_W = 16;
    localparam int PC_W    = 16;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched instruction while decode is stalled.
module fetch_skid_buf
    import instruction_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_clear,
    input  logic [INSTR_W-1:0] i_data,
    input  logic [PC_W-1:0]    i_pc,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_data,
    output logic [PC_W-1:0]    o_pc
);

    logic               r_valid;
    logic [INSTR_W-1:0] r_data;
    logic [PC_W-1:0]    r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_pc    <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_pc    = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: single-outstanding memory requests, IF/ID register with skid, redirect handling.
//   state   | meaning
//   S_REQ   | ready to issue a fetch at the current PC
//   S_WAIT  | request outstanding, response will be kept
//   S_DRAIN | request outstanding, response will be discarded (redirected)
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_en,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               stall,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid
);

    fetch_state_e       r_state;
    fetch_state_e       w_state_nxt;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    r_req_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_instr_pc;
    logic               r_instr_valid;

    logic               w_req;
    logic               w_ack_acc;
    logic               w_consume;
    logic               w_skid_valid;
    logic               w_skid_load;
    logic               w_skid_clear;
    logic [INSTR_W-1:0] w_skid_data;
    logic [PC_W-1:0]    w_skid_pc;

    assign w_ack_acc    = (r_state == S_WAIT) && imem_ack && !redirect_en;
    assign w_consume    = r_instr_valid && !stall;
    assign w_skid_load  = w_ack_acc && r_instr_valid && stall;
    assign w_skid_clear = redirect_en || (w_skid_valid && w_consume);

    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (imem_rdata),
        .i_pc    (r_req_pc),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data),
        .o_pc    (w_skid_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A full skid means no request can be in flight, so issue is blocked until it drains.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        case (r_state)
            S_REQ: begin
                if (!redirect_en && !w_skid_valid && !reset) begin
                    w_req       = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_en) begin
                    w_state_nxt = imem_ack ? S_REQ : S_DRAIN;
                end else if (imem_ack) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_ack) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
        end else if (redirect_en) begin
            r_pc <= redirect_pc;
        end else if (w_req) begin
            r_pc     <= r_pc + 16'd1;
            r_req_pc <= r_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else if (redirect_en) begin
            r_instr_valid <= 1'b0;
        end else if (w_skid_valid && w_consume) begin
            r_instr       <= w_skid_data;
            r_instr_pc    <= w_skid_pc;
            r_instr_valid <= 1'b1;
        end else if (w_ack_acc && (!r_instr_valid || !stall)) begin
            r_instr       <= imem_rdata;
            r_instr_pc    <= r_req_pc;
            r_instr_valid <= 1'b1;
        end else if (w_consume) begin
            r_instr_valid <= 1'b0;
        end
    end

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: normal fetch, stall/skid, redirects, PC wrap, reset mid-request.
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        redirect_en;
    logic [15:0] redirect_pc;
    logic        stall;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;

    int n_checks = 0;
    int n_pass   = 0;

    instruction_fetch #(.RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [15:0] e_instr, input logic [15:0] e_pc,
                           input logic e_valid);
        check({tag, "_instr"}, instr, e_instr);
        check({tag, "_pc"}, instr_pc, e_pc);
        check({tag, "_valid"}, {15'd0, instr_valid}, {15'd0, e_valid});
    endtask

    task automatic chk_req(input string tag, input logic e_req, input logic [15:0] e_addr);
        check({tag, "_req"}, {15'd0, imem_req}, {15'd0, e_req});
        if (e_req) check({tag, "_addr"}, imem_addr, e_addr);
    endtask

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 16'h0; redirect_en = 1'b0;
        redirect_pc = 16'h0; stall = 1'b0;
        #3;
        chk_out("rst", 16'h0000, 16'h0000, 1'b0);
        chk_req("rst", 1'b0, 16'h0000);
        repeat (2) @(posedge clk);
        #1;

        // basic fetch, k=1
        reset = 1'b0; #1;
        chk_req("f0", 1'b1, 16'h0000);
        tick(); imem_ack = 1'b1; imem_rdata = 16'h1234; #1;
        chk_req("f0_wait", 1'b0, 16'h0000);
        tick(); imem_ack = 1'b0; #1;
        chk_out("f0_out", 16'h1234, 16'h0000, 1'b1);
        chk_req("f1", 1'b1, 16'h0001);
        tick(); #1;
        chk_out("f0_consumed", 16'h1234, 16'h0000, 1'b0);

        // stall with two acks: output holds first, skid holds second
        stall = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hAAAA; #1;
        tick(); imem_ack = 1'b0; #1;
        chk_out("st_a", 16'hAAAA, 16'h0001, 1'b1);
        chk_req("st_f2", 1'b1, 16'h0002);
        tick(); imem_ack = 1'b1; imem_rdata = 16'hBBBB; #1;
        tick(); imem_ack = 1'b0; #1;
        chk_out("st_hold1", 16'hAAAA, 16'h0001, 1'b1);
        chk_req("st_noreq1", 1'b0, 16'h0000);
        tick(); #1;
        chk_out("st_hold2", 16'hAAAA, 16'h0001, 1'b1);
        chk_req("st_noreq2", 1'b0, 16'h0000);
        stall = 1'b0;
        tick(); #1;
        chk_out("st_b", 16'hBBBB, 16'h0002, 1'b1);
        chk_req("st_f3", 1'b1, 16'h0003);

        // redirect during S_WAIT, ack arrives two cycles later and is discarded
        tick(); redirect_en = 1'b1; redirect_pc = 16'h0040; #1;
        chk_out("rd_empty", 16'hBBBB, 16'h0002, 1'b0);
        chk_req("rd_blk", 1'b0, 16'h0000);
        tick(); redirect_en = 1'b0; #1;
        chk_req("rd_drain", 1'b0, 16'h0000);
        tick(); imem_ack = 1'b1; imem_rdata = 16'hDEAD; #1;
        chk_req("rd_drain_ack", 1'b0, 16'h0000);
        tick(); imem_ack = 1'b0; #1;
        chk_out("rd_discard", 16'hBBBB, 16'h0002, 1'b0);
        chk_req("rd_target", 1'b1, 16'h0040);

        // redirect in same cycle as ack: data dropped, straight back to S_REQ
        tick(); imem_ack = 1'b1; imem_rdata = 16'hCAFE; redirect_en = 1'b1;
        redirect_pc = 16'hFFFF; #1;
        chk_req("ra_blk", 1'b0, 16'h0000);
        tick(); imem_ack = 1'b0; redirect_en = 1'b0; #1;
        chk_out("ra_drop", 16'hBBBB, 16'h0002, 1'b0);
        chk_req("ra_target", 1'b1, 16'hFFFF);

        // PC wrap
        tick(); imem_ack = 1'b1; imem_rdata = 16'h1111; #1;
        tick(); imem_ack = 1'b0; #1;
        chk_out("wrap_out", 16'h1111, 16'hFFFF, 1'b1);
        chk_req("wrap_req", 1'b1, 16'h0000);

        // reset asserted with a request outstanding
        stall = 1'b1;
        tick(); #1;
        chk_out("pre_rst", 16'h1111, 16'hFFFF, 1'b1);
        reset = 1'b1; #1;
        chk_out("mid_rst", 16'h0000, 16'h0000, 1'b0);
        chk_req("mid_rst", 1'b0, 16'h0000);
        check("mid_rst_addr", imem_addr, 16'h0000);
        stall = 1'b0;
        tick(); reset = 1'b0; #1;
        chk_req("post_rst", 1'b1, 16'h0000);
        tick(); imem_ack = 1'b1; imem_rdata = 16'h7777; #1;
        tick(); imem_ack = 1'b0; #1;
        chk_out("post_rst_out", 16'h7777, 16'h0000, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, giving the PC loaded on reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port imem_req, output, 1 bit: a fetch request to instruction memory, at most one outstanding.
REQ-005 The block SHALL have port imem_addr, output, 16 bits: the word address of the request, equal to the current PC.
REQ-006 The block SHALL have port imem_ack, input, 1 bit: response valid, at least 1 cycle after the request cycle.
REQ-007 The block SHALL have port imem_rdata, input, 16 bits: the instruction word, valid when imem_ack=1.
REQ-008 The block SHALL have port redirect_en, input, 1 bit: a branch/jump taken, with a 1-cycle pulse.
REQ-009 The block SHALL have port redirect_pc, input, 16 bits: the target PC, sampled when redirect_en=1.
REQ-010 The block SHALL have port stall, input, 1 bit: decode is not ready, so the held instruction is not consumed.
REQ-011 The block SHALL have port instr, output, 16 bits: the IF/ID instruction register driving the decode field splitter (opcode[15:12], rs[11:9], rt[8:6], rd[5:3], funct/immed low bits).
REQ-012 The block SHALL have port instr_pc, output, 16 bits: the PC of instr.
REQ-013 The block SHALL have port instr_valid, output, 1 bit: instr/instr_pc hold a live instruction.

Function
REQ-014 The block SHALL implement FSM states S_REQ (ready to issue), S_WAIT (request outstanding) and S_DRAIN (outstanding response to be discarded).
REQ-015 The block SHALL assert imem_req combinationally when state=S_REQ, the skid buffer is empty and redirect_en=0; the next state SHALL be S_WAIT.
REQ-016 The block SHALL increment the PC by 1 in the cycle a request issues, wrapping 16'hFFFF to 16'h0000.
REQ-017 On imem_ack in S_WAIT, the block SHALL load {imem_rdata, request PC} into instr/instr_pc with instr_valid=1 next cycle if instr_valid=0 or stall=0; otherwise it SHALL load the one-entry skid buffer. The next state SHALL be S_REQ.
REQ-018 The output register SHALL be consumed in any cycle with instr_valid=1 and stall=0; with no new data, instr_valid SHALL fall to 0 next cycle.
REQ-019 When the skid buffer is full and output is consumed, the skid entry SHALL move to the output register next cycle and the skid SHALL empty.
REQ-020 While stall=1 and instr_valid=1, instr and instr_pc SHALL remain unchanged.
REQ-021 Fetch-to-output latency SHALL be: request in cycle N, ack in cycle N+k (k≥1), instr_valid=1 in cycle N+k+1.
REQ-022 redirect_en SHALL have priority over every other event: PC<=redirect_pc, instr_valid<=0, skid emptied, imem_req=0 that cycle.
REQ-023 On a redirect in S_WAIT without a same-cycle ack, the next state SHALL be S_DRAIN; with a same-cycle ack, the response SHALL be discarded and the next state SHALL be S_REQ.
REQ-024 In S_DRAIN, imem_ack SHALL be discarded and the next state SHALL be S_REQ; a further redirect in S_DRAIN SHALL only update the PC.
REQ-025 instr SHALL keep its last value when instr_valid=0.
REQ-026 imem_ack outside S_WAIT/S_DRAIN SHALL be ignored.

Reset
REQ-027 On reset, the block SHALL set PC=RESET_PC, state=S_REQ, instr=16'h0000, instr_pc=16'h0000, instr_valid=0 and skid empty; imem_req SHALL be 0 while reset=1.
REQ-028 A reset assertion mid-request SHALL abandon the outstanding request, with no drain.

Structure
REQ-029 Shared package SHALL hold INSTR_W=16, PC_W=16 and the fetch state enum {S_REQ, S_WAIT, S_DRAIN}.
REQ-030 The skid buffer SHALL be a sub-module, fetch_skid_buf (one entry: data, pc, valid).

Verification
REQ-031 Bench SHALL cover: reset release, memory acks with k=1 returning 16'h1234 -> imem_addr 0x0000 then 0x0001; instr=16'h1234, instr_pc=0x0000 valid 2 cycles after first req.
REQ-032 Bench SHALL cover: stall=1 for 3 cycles while two acks arrive -> output holds first, skid holds second, no third req; on stall=0 both emerge in order.
REQ-033 Bench SHALL cover: redirect_pc=0x0040 during S_WAIT with ack 2 cycles later -> ack discarded, next imem_addr=0x0040, no instr_valid from the discarded data.
REQ-034 Bench SHALL cover: redirect in the same cycle as ack -> data dropped, next req to the target, state S_REQ.
REQ-035 Bench SHALL cover: PC at 0xFFFF -> request to 0xFFFF then 0x0000.
REQ-036 Bench SHALL cover: reset asserted in S_WAIT -> all outputs 0 immediately, and after release the first req is to RESET_PC.
